// File: rtl/preamble_capture_ctrl.sv
// preamble_capture_ctrl: gates one fixed-length, tlast-framed burst of
// detector samples per accepted trigger, emits one phase word per burst,
// then discards a programmable holdoff before re-arming.
// Optional build macro PREAMBLE_CAPTURE_STATS_EN enables the burst/missed
// counters; without it both counter ports read zero.
//
// state     | meaning
// S_IDLE    | discard beats, wait for tlast with enable as trigger
// S_CAPTURE | forward beats until burst_len samples have been sent
// S_HOLDOFF | discard holdoff_len beats, then re-arm
module preamble_capture_ctrl #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [LEN_W-1:0] holdoff_len,
  input  logic [WIDTH-1:0] i_samples_tdata,
  input  logic             i_samples_tlast,
  input  logic             i_samples_tvalid,
  output logic             i_samples_tready,
  input  logic [15:0]      i_phase_tdata,
  input  logic             i_phase_tlast,
  input  logic             i_phase_tvalid,
  output logic             i_phase_tready,
  output logic [WIDTH-1:0] o_samples_tdata,
  output logic             o_samples_tlast,
  output logic             o_samples_tvalid,
  input  logic             o_samples_tready,
  output logic [15:0]      o_phase_tdata,
  output logic             o_phase_tvalid,
  input  logic             o_phase_tready,
  output logic             busy,
  output logic [CNT_W-1:0] burst_count,
  output logic [CNT_W-1:0] missed_count
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLDOFF} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      phase_q, phase_d;
  logic             phase_valid_q, phase_valid_d;
  logic             burst_inc, missed_inc;

  logic             accept;
  logic             beat;
  logic             phase_free;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] cnt_next;

  // Both streams are consumed as one joint beat so they never slip.
  assign accept = (state_q == S_CAPTURE) ? (~out_valid_q | o_samples_tready) : 1'b1;
  assign beat   = i_samples_tvalid & i_phase_tvalid & accept;
  assign i_samples_tready = i_phase_tvalid & accept;
  assign i_phase_tready   = i_samples_tvalid & accept;

  // A phase word being taken this cycle frees the slot for a coincident trigger.
  assign phase_free = ~phase_valid_q | o_phase_tready;
  assign len_eff    = (burst_len == '0) ? LEN_W'(1) : burst_len;
  assign cnt_next   = cnt_q + LEN_W'(1);

  // Next-state, output stage and phase register update.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    hold_d        = hold_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q;
    phase_d       = phase_q;
    phase_valid_d = phase_valid_q;
    burst_inc     = 1'b0;
    missed_inc    = 1'b0;

    if (out_valid_q && o_samples_tready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (phase_valid_q && o_phase_tready) begin
      phase_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (beat && i_samples_tlast && enable) begin
          if (phase_free) begin
            len_d         = len_eff;
            hold_d        = holdoff_len;
            phase_d       = i_phase_tdata;
            phase_valid_d = 1'b1;
            out_data_d    = i_samples_tdata;
            out_valid_d   = 1'b1;
            out_last_d    = (len_eff == LEN_W'(1));
            burst_inc     = 1'b1;
            if (len_eff == LEN_W'(1)) begin
              cnt_d   = '0;
              state_d = (holdoff_len != '0) ? S_HOLDOFF : S_IDLE;
            end else begin
              cnt_d   = LEN_W'(1);
              state_d = S_CAPTURE;
            end
          end else begin
            missed_inc = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (beat) begin
          out_data_d  = i_samples_tdata;
          out_valid_d = 1'b1;
          missed_inc  = i_samples_tlast;
          if (cnt_next == len_q) begin
            out_last_d = 1'b1;
            cnt_d      = '0;
            state_d    = (hold_q != '0) ? S_HOLDOFF : S_IDLE;
          end else begin
            out_last_d = 1'b0;
            cnt_d      = cnt_next;
          end
        end
      end
      S_HOLDOFF: begin
        if (beat) begin
          missed_inc = i_samples_tlast;
          if (cnt_next == hold_q) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      hold_q        <= '0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      hold_q        <= hold_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_valid_q   <= out_valid_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
    end
  end

  assign o_samples_tdata  = out_data_q;
  assign o_samples_tlast  = out_last_q;
  assign o_samples_tvalid = out_valid_q;
  assign o_phase_tdata    = phase_q;
  assign o_phase_tvalid   = phase_valid_q;
  assign busy             = (state_q != S_IDLE);

  logic unused_ok;

`ifdef PREAMBLE_CAPTURE_STATS_EN
  logic [CNT_W-1:0] burst_cnt_q, missed_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q  <= '0;
      missed_cnt_q <= '0;
    end else begin
      if (burst_inc && (burst_cnt_q != '1)) burst_cnt_q <= burst_cnt_q + CNT_W'(1);
      if (missed_inc && (missed_cnt_q != '1)) missed_cnt_q <= missed_cnt_q + CNT_W'(1);
    end
  end

  assign burst_count  = burst_cnt_q;
  assign missed_count = missed_cnt_q;
  assign unused_ok    = i_phase_tlast;
`else
  assign burst_count  = '0;
  assign missed_count = '0;
  assign unused_ok    = ^{i_phase_tlast, burst_inc, missed_inc};
`endif

endmodule

// File: tb/tb_preamble_capture_ctrl.sv
// Directed bench for preamble_capture_ctrl with hand-computed expectations.
module tb_preamble_capture_ctrl;

  localparam int WIDTH = 32;
  localparam int LEN_W = 16;
  localparam int CNT_W = 32;
`ifdef PREAMBLE_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic [LEN_W-1:0] holdoff_len = '0;
  logic [WIDTH-1:0] i_samples_tdata = '0;
  logic             i_samples_tlast = 1'b0;
  logic             i_samples_tvalid = 1'b0;
  logic             i_samples_tready;
  logic [15:0]      i_phase_tdata = '0;
  logic             i_phase_tlast = 1'b0;
  logic             i_phase_tvalid = 1'b0;
  logic             i_phase_tready;
  logic [WIDTH-1:0] o_samples_tdata;
  logic             o_samples_tlast;
  logic             o_samples_tvalid;
  logic             o_samples_tready = 1'b1;
  logic [15:0]      o_phase_tdata;
  logic             o_phase_tvalid;
  logic             o_phase_tready = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] burst_count;
  logic [CNT_W-1:0] missed_count;

  int checks = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;
  bit rdy_fixed = 1'b1;

  logic [32:0] out_q[$];
  logic [15:0] ph_q[$];

  preamble_capture_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .burst_len(burst_len), .holdoff_len(holdoff_len),
    .i_samples_tdata(i_samples_tdata), .i_samples_tlast(i_samples_tlast),
    .i_samples_tvalid(i_samples_tvalid), .i_samples_tready(i_samples_tready),
    .i_phase_tdata(i_phase_tdata), .i_phase_tlast(i_phase_tlast),
    .i_phase_tvalid(i_phase_tvalid), .i_phase_tready(i_phase_tready),
    .o_samples_tdata(o_samples_tdata), .o_samples_tlast(o_samples_tlast),
    .o_samples_tvalid(o_samples_tvalid), .o_samples_tready(o_samples_tready),
    .o_phase_tdata(o_phase_tdata), .o_phase_tvalid(o_phase_tvalid),
    .o_phase_tready(o_phase_tready), .busy(busy),
    .burst_count(burst_count), .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    o_samples_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  always @(negedge clk) begin
    if (reset_n && o_samples_tvalid && o_samples_tready) out_q.push_back({o_samples_tlast, o_samples_tdata});
    if (reset_n && o_phase_tvalid && o_phase_tready) ph_q.push_back(o_phase_tdata);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    i_samples_tvalid = 1'b0;
    i_phase_tvalid = 1'b0;
    i_samples_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_q.delete();
    ph_q.delete();
  endtask

  // Beat k (1..n): data 0x1000+k, phase pbase+k, tlast from mask[k].
  task automatic drive(input int n, input logic [31:0] mask, input logic [15:0] pbase, input int stop_after);
    bit xfer;
    int guard;
    for (int k = 1; k <= n; k++) begin
      i_samples_tdata  = 32'h1000 + 32'(k);
      i_samples_tlast  = mask[k];
      i_phase_tdata    = pbase + 16'(k);
      i_samples_tvalid = 1'b1;
      i_phase_tvalid   = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        xfer = i_samples_tready & i_phase_tready;
        @(posedge clk);
        #1;
        guard++;
      end while (!xfer && guard < 100);
      checks++;
      if (!xfer) begin
        failures++;
        $display("FAIL beat_timeout: beat %0d got no handshake, required handshake within 100 cycles", k);
      end
      if (k == stop_after) break;
    end
    i_samples_tvalid = 1'b0;
    i_phase_tvalid   = 1'b0;
    i_samples_tlast  = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++;
    if ({o_samples_tvalid, o_samples_tlast, o_phase_tvalid, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000", {o_samples_tvalid, o_samples_tlast, o_phase_tvalid, busy});
    end
    checks++;
    if (burst_count !== '0 || missed_count !== '0) begin
      failures++;
      $display("FAIL reset_counts: got %0d/%0d required 0/0", burst_count, missed_count);
    end
    do_reset();
  endtask

  task automatic test_basic_burst();
    logic [32:0] exp;
    do_reset();
    enable = 1'b1; burst_len = 16'd4; holdoff_len = 16'd2; o_phase_tready = 1'b1;
    drive(20, 32'h0000_0020, 16'h011E, 0);
    drain();
    checks++;
    if (out_q.size() !== 4) begin
      failures++;
      $display("FAIL basic_len: got %0d beats required 4", out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = {(i == 3), 32'h1005 + 32'(i)};
        checks++;
        if (out_q[i] !== exp) begin
          failures++;
          $display("FAIL basic_beat%0d: got %h required %h", i, out_q[i], exp);
        end
      end
    end
    checks++;
    if (ph_q.size() !== 1 || ph_q[0] !== 16'h0123) begin
      failures++;
      $display("FAIL basic_phase: got %0d words first %h required 1 word 0123", ph_q.size(), ph_q.size() > 0 ? ph_q[0] : 16'hxxxx);
    end
    checks++;
    if (burst_count !== (STATS ? 32'd1 : 32'd0) || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_count: got burst %0d busy %b required %0d busy 0", burst_count, busy, STATS ? 1 : 0);
    end
  endtask

  task automatic test_missed_tlast();
    logic [32:0] exp;
    int beats[8] = '{5, 6, 7, 8, 12, 13, 14, 15};
    do_reset();
    enable = 1'b1; burst_len = 16'd4; holdoff_len = 16'd2;
    drive(20, 32'h0000_14A0, 16'h0100, 0);
    drain();
    checks++;
    if (out_q.size() !== 8) begin
      failures++;
      $display("FAIL missed_len: got %0d beats required 8", out_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp = {(i == 3 || i == 7), 32'h1000 + 32'(beats[i])};
        checks++;
        if (out_q[i] !== exp) begin
          failures++;
          $display("FAIL missed_beat%0d: got %h required %h", i, out_q[i], exp);
        end
      end
    end
    checks++;
    if (ph_q.size() !== 2 || ph_q[0] !== 16'h0105 || ph_q[1] !== 16'h010C) begin
      failures++;
      $display("FAIL missed_phase: got %0d words required 0105,010C", ph_q.size());
    end
    checks++;
    if (burst_count !== (STATS ? 32'd2 : 32'd0) || missed_count !== (STATS ? 32'd2 : 32'd0)) begin
      failures++;
      $display("FAIL missed_counts: got %0d/%0d required %0d/%0d", burst_count, missed_count, STATS ? 2 : 0, STATS ? 2 : 0);
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    enable = 1'b1; burst_len = 16'd0; holdoff_len = 16'd0;
    drive(6, 32'h0000_0008, 16'h0200, 0);
    drain();
    checks++;
    if (out_q.size() !== 1 || out_q[0] !== {1'b1, 32'h0000_1003}) begin
      failures++;
      $display("FAIL len_zero: got %0d beats first %h required 1 beat 100001003", out_q.size(), out_q.size() > 0 ? out_q[0] : 33'hx);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    do_reset();
    enable = 1'b1; burst_len = 16'd2; holdoff_len = 16'd0;
    drive(8, 32'h0000_0014, 16'h0100, 0);
    drain();
    checks++;
    if (out_q.size() !== 4) begin
      failures++;
      $display("FAIL b2b_len: got %0d beats required 4", out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = {(i == 1 || i == 3), 32'h1002 + 32'(i)};
        checks++;
        if (out_q[i] !== exp) begin
          failures++;
          $display("FAIL b2b_beat%0d: got %h required %h", i, out_q[i], exp);
        end
      end
    end
    checks++;
    if (ph_q.size() !== 2 || burst_count !== (STATS ? 32'd2 : 32'd0)) begin
      failures++;
      $display("FAIL b2b_bursts: got %0d phase words burst %0d required 2 and %0d", ph_q.size(), burst_count, STATS ? 2 : 0);
    end
  endtask

  task automatic test_phase_stall();
    do_reset();
    enable = 1'b1; burst_len = 16'd2; holdoff_len = 16'd0; o_phase_tready = 1'b0;
    drive(8, 32'h0000_0044, 16'h0300, 0);
    drain();
    checks++;
    if (out_q.size() !== 2 || out_q[1] !== {1'b1, 32'h0000_1003}) begin
      failures++;
      $display("FAIL stall_len: got %0d beats required 2 ending 100001003", out_q.size());
    end
    checks++;
    if (o_phase_tvalid !== 1'b1 || o_phase_tdata !== 16'h0302) begin
      failures++;
      $display("FAIL stall_phase: got valid %b data %h required 1 0302", o_phase_tvalid, o_phase_tdata);
    end
    checks++;
    if (missed_count !== (STATS ? 32'd1 : 32'd0) || burst_count !== (STATS ? 32'd1 : 32'd0)) begin
      failures++;
      $display("FAIL stall_counts: got %0d/%0d required %0d/%0d", burst_count, missed_count, STATS ? 1 : 0, STATS ? 1 : 0);
    end
    o_phase_tready = 1'b1;
  endtask

  task automatic test_random_ready();
    int bad;
    do_reset();
    enable = 1'b1; burst_len = 16'd16; holdoff_len = 16'd0;
    rand_rdy = 1'b1;
    drive(20, 32'h0000_0002, 16'h0400, 0);
    repeat (60) @(posedge clk);
    rand_rdy = 1'b0;
    drain();
    checks++;
    if (out_q.size() !== 16) begin
      failures++;
      $display("FAIL rand_len: got %0d beats required 16", out_q.size());
    end
    bad = 0;
    for (int i = 0; i < out_q.size() && i < 16; i++) begin
      if (out_q[i] !== {(i == 15), 32'h1001 + 32'(i)}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rand_order: got %0d wrong beats required 0", bad);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    enable = 1'b1; burst_len = 16'd8; holdoff_len = 16'd0;
    drive(10, 32'h0000_0004, 16'h0500, 4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: got %b required 1", busy);
    end
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_samples_tvalid, o_samples_tlast, o_phase_tvalid, busy} !== 4'b0000 || burst_count !== '0 || missed_count !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got flags %b counts %0d/%0d required 0000 0/0",
               {o_samples_tvalid, o_samples_tlast, o_phase_tvalid, busy}, burst_count, missed_count);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_q.delete();
    ph_q.delete();
    drive(12, 32'h0000_0004, 16'h0500, 0);
    drain();
    checks++;
    if (out_q.size() !== 8 || out_q[0] !== {1'b0, 32'h0000_1002} || out_q[out_q.size()-1] !== {1'b1, 32'h0000_1009}) begin
      failures++;
      $display("FAIL abort_rerun: got %0d beats required 8 from 1002 to 1009 with tlast", out_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_missed_tlast();
    test_len_zero();
    test_back_to_back();
    test_phase_stall();
    test_random_ready();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
